pipeline_drain_fifo: RTL

Credit-managed elastic buffer at the output of a fixed-latency, non-stallable datapath built from reset-able delay registers. The upstream controller may issue into the pipeline only while this block grants a credit. Every issued word is then guaranteed a slot when it emerges PIPE_LATENCY cycles later. The block presents buffered words to a stalling downstream consumer over a valid/ready handshake.

---
 rtl/pipeline_drain_fifo.sv | 139 +++++++++++++
 1 files changed

// File: rtl/pipeline_drain_fifo.sv
// ---------------------------------------------------------------------------
// pipeline_drain_fifo
//
// Elastic buffer at the tail of a fixed-latency, non-stallable datapath.
// Upstream may launch a word only while issue_ok is high. Each grant reserves
// one FIFO slot, so every launched word has room when it comes out of the
// pipeline PIPE_LATENCY cycles later. Buffered words go to a stalling
// consumer over a first-word-fall-through valid/ready interface.
//
// Ports
//   clk, rst     clock; synchronous active-high reset
//   issue        upstream launches a word this cycle
//   issue_ok     credit available (decoded from registered credit only)
//   in_valid     word emerging from the fixed pipeline
//   in_data      emerging data word
//   out_valid    FIFO non-empty
//   out_data     head word (combinational read of the head slot)
//   out_ready    consumer accepts the head word
//   count        current occupancy
//   overflow     sticky protocol-error flag, cleared only by rst
// ---------------------------------------------------------------------------
module pipeline_drain_fifo #(
    parameter int BITWIDTH     = 8,
    parameter int DEPTH        = 8,
    parameter int PIPE_LATENCY = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     issue,
    output logic                     issue_ok,
    input  logic                     in_valid,
    input  logic [BITWIDTH-1:0]      in_data,
    output logic                     out_valid,
    output logic [BITWIDTH-1:0]      out_data,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [BITWIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]       count_q, count_d;
    logic [CW-1:0]       credit_q, credit_d;
    logic                overflow_q, overflow_d;

    logic full;
    logic pop;
    logic push;
    logic drop;
    logic issue_acc;
    logic issue_bad;

    assign full      = (count_q == DEPTH_C);
    assign issue_ok  = !rst && (credit_q != '0);
    assign out_valid = !rst && (count_q != '0);
    assign out_data  = mem_q[rd_ptr_q];
    assign count     = count_q;
    assign overflow  = overflow_q;

    assign pop       = out_valid && out_ready;
    assign issue_acc = issue && issue_ok;
    assign issue_bad = issue && !issue_ok;
    // A pop in the same cycle frees the slot the incoming word is written to.
    assign push      = in_valid && (!full || pop);
    assign drop      = in_valid && full && !pop;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        credit_d   = credit_q;
        overflow_d = overflow_q | issue_bad | drop;

        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // Saturate on return so a stray in_valid from a broken upstream cannot
        // inflate the credit pool beyond the physical depth.
        case ({issue_acc, pop})
            2'b10: credit_d = credit_q - CW'(1);
            2'b01: begin
                if (credit_q != DEPTH_C) begin
                    credit_d = credit_q + CW'(1);
                end
            end
            default: credit_d = credit_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            credit_q   <= DEPTH_C;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            credit_q   <= credit_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is not reset; only the pointers and counters define validity.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    a_count_bound: assert property (@(posedge clk) disable iff (rst)
        count_q <= DEPTH_C);

    a_credit_bound: assert property (@(posedge clk) disable iff (rst)
        credit_q <= DEPTH_C);

    // At most PIPE_LATENCY words can be in flight, so when the pipeline is
    // shorter than the buffer an exhausted credit pool implies buffered words.
    a_credit_vs_inflight: assert property (@(posedge clk) disable iff (rst)
        (credit_q == '0 && PIPE_LATENCY < DEPTH) |-> (count_q != '0));

endmodule
